icb_copy_dma: RTL and testbench

Single-channel word-copy engine acting as an ICB master. It reads `len` 32-bit words starting at `src_addr` and writes them to `dst_addr` over one ICB master port, one transaction outstanding at a time. It sits directly upstream of ICB slaves such as the bench memory model `icb_slave_bfm`, and is the first stimulus source in the ICB testbench that drives real master traffic.

---
 rtl/icb_pkg.sv | 17 +
 rtl/icb_copy_dma_if.sv | 31 +++
 rtl/icb_copy_dma.sv | 128 ++++++++++++
 tb/tb_icb_copy_dma.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/icb_pkg.sv
// Shared ICB definitions: copy-engine state encoding and bus constants.
package icb_pkg;

  localparam int          ICB_DATA_W     = 32;
  localparam logic [3:0]  ICB_WMASK_FULL = 4'hF;
  localparam int          ICB_WORD_BYTES = 4;

  typedef enum logic [2:0] {
    IDLE,
    RD_CMD,
    RD_RSP,
    WR_CMD,
    WR_RSP,
    FIN
  } icb_dma_state_e;

endpackage

// File: rtl/icb_copy_dma_if.sv
// ICB command/response channel bundle with master and slave views.
interface icb_copy_dma_if
  import icb_pkg::*;
#(
  parameter int ADDR_W = 32
);

  logic                      icb_cmd_valid;
  logic                      icb_cmd_ready;
  logic [ADDR_W-1:0]         icb_cmd_addr;
  logic                      icb_cmd_read;
  logic [ICB_DATA_W-1:0]     icb_cmd_wdata;
  logic [ICB_DATA_W/8-1:0]   icb_cmd_wmask;
  logic                      icb_rsp_valid;
  logic                      icb_rsp_ready;
  logic [ICB_DATA_W-1:0]     icb_rsp_rdata;
  logic                      icb_rsp_err;

  modport master (
    output icb_cmd_valid, icb_cmd_addr, icb_cmd_read, icb_cmd_wdata, icb_cmd_wmask,
    output icb_rsp_ready,
    input  icb_cmd_ready, icb_rsp_valid, icb_rsp_rdata, icb_rsp_err
  );

  modport slave (
    input  icb_cmd_valid, icb_cmd_addr, icb_cmd_read, icb_cmd_wdata, icb_cmd_wmask,
    input  icb_rsp_ready,
    output icb_cmd_ready, icb_rsp_valid, icb_rsp_rdata, icb_rsp_err
  );

endinterface

// File: rtl/icb_copy_dma.sv
// Single-channel word-copy engine: read one word, write it, repeat; one ICB
// transaction outstanding at a time.
module icb_copy_dma
  import icb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [LEN_W-1:0]  xfer_cnt,
  icb_copy_dma_if.master    icb
);

  localparam logic [ADDR_W-1:0] WORD_STEP = ADDR_W'(ICB_WORD_BYTES);
  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(ICB_WORD_BYTES - 1);

  icb_dma_state_e        state_q, state_d;
  logic [ADDR_W-1:0]     src_q, src_d;
  logic [ADDR_W-1:0]     dst_q, dst_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic [LEN_W-1:0]      cnt_q, cnt_d;
  logic [LEN_W-1:0]      cnt_inc;
  logic [ICB_DATA_W-1:0] data_q, data_d;
  logic                  err_q, err_d;

  assign cnt_inc = cnt_q + LEN_W'(1);

  // NOTE: every *_d gets a hold default before the case, so no path through
  // this block leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          err_d = 1'b0;
          if (len != '0) begin
            src_d   = src_addr & WORD_MASK;
            dst_d   = dst_addr & WORD_MASK;
            len_d   = len;
            cnt_d   = '0;
            state_d = RD_CMD;
          end else begin
            state_d = FIN;
          end
        end
      end
      RD_CMD: if (icb.icb_cmd_ready) state_d = RD_RSP;
      RD_RSP: begin
        if (icb.icb_rsp_valid) begin
          data_d = icb.icb_rsp_rdata;
          if (icb.icb_rsp_err) begin
            err_d   = 1'b1;
            state_d = FIN;
          end else begin
            state_d = WR_CMD;
          end
        end
      end
      WR_CMD: if (icb.icb_cmd_ready) state_d = WR_RSP;
      WR_RSP: begin
        if (icb.icb_rsp_valid) begin
          if (icb.icb_rsp_err) begin
            err_d   = 1'b1;
            state_d = FIN;
          end else begin
            cnt_d   = cnt_inc;
            src_d   = src_q + WORD_STEP;
            dst_d   = dst_q + WORD_STEP;
            state_d = (cnt_inc == len_q) ? FIN : RD_CMD;
          end
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state flops use non-blocking assignments so every register samples
  // the pre-edge values of the others; blocking here would create ordering races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  // Command fields are zero outside the command states so idle bus is quiet.
  assign icb.icb_cmd_valid = (state_q == RD_CMD) || (state_q == WR_CMD);
  assign icb.icb_cmd_read  = (state_q == RD_CMD);
  assign icb.icb_cmd_addr  = (state_q == RD_CMD) ? src_q :
                             (state_q == WR_CMD) ? dst_q : '0;
  assign icb.icb_cmd_wdata = (state_q == WR_CMD) ? data_q : '0;
  assign icb.icb_cmd_wmask = (state_q == WR_CMD) ? ICB_WMASK_FULL : '0;
  assign icb.icb_rsp_ready = (state_q == RD_RSP) || (state_q == WR_RSP);

  assign busy     = (state_q != IDLE) && (state_q != FIN);
  assign done     = (state_q == FIN);
  assign err      = err_q;
  assign xfer_cnt = cnt_q;

endmodule

// File: tb/tb_icb_copy_dma.sv
// Self-checking bench for icb_copy_dma: memory slave model, directed corner
// cases and randomized copies checked against a word-copy reference.
module tb_icb_copy_dma;
  import icb_pkg::*;

  localparam int ADDR_W = 32;
  localparam int LEN_W  = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] src_addr = '0;
  logic [ADDR_W-1:0] dst_addr = '0;
  logic [LEN_W-1:0]  len = '0;
  logic              busy, done, err;
  logic [LEN_W-1:0]  xfer_cnt;

  icb_copy_dma_if #(.ADDR_W(ADDR_W)) icb ();

  icb_copy_dma #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .src_addr (src_addr),
    .dst_addr (dst_addr),
    .len      (len),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .xfer_cnt (xfer_cnt),
    .icb      (icb)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Memory: bench preloads and slave writes kept apart; newest entry wins.
  typedef struct { longint t; logic [31:0] d; } cell_t;
  cell_t init_mem [logic [31:0]];
  cell_t wr_mem   [logic [31:0]];

  function automatic logic [31:0] read_mem(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    if (wr_mem.exists(w) && (!init_mem.exists(w) || wr_mem[w].t >= init_mem[w].t))
      return wr_mem[w].d;
    if (init_mem.exists(w)) return init_mem[w].d;
    return w ^ 32'hA5A5_5A5A;
  endfunction

  task automatic poke(input logic [31:0] a, input logic [31:0] d);
    init_mem[{a[31:2], 2'b00}] = '{$time, d};
  endtask

  // Slave control (written by the main sequence only).
  int stall_rd_at = -1;
  int err_wr_at   = -1;
  bit rand_ready  = 1'b0;

  // Slave state (written by the slave only).
  int rd_seen = 0, rd_fire_cnt = 0, wr_fire_cnt = 0, bad_mask = 0;

  initial begin : slave
    logic cmd_fire, rsp_fire, c_read, bad;
    logic [31:0] c_addr, c_wdata;
    logic [3:0]  c_mask;
    bit in_cmd;
    int stall_left;
    in_cmd = 1'b0;
    stall_left = 0;
    icb.icb_cmd_ready = 1'b1;
    icb.icb_rsp_valid = 1'b0;
    icb.icb_rsp_rdata = '0;
    icb.icb_rsp_err   = 1'b0;
    forever begin
      @(negedge clk);
      cmd_fire = icb.icb_cmd_valid && icb.icb_cmd_ready;
      rsp_fire = icb.icb_rsp_valid && icb.icb_rsp_ready;
      c_read   = icb.icb_cmd_read;
      c_addr   = icb.icb_cmd_addr;
      c_wdata  = icb.icb_cmd_wdata;
      c_mask   = icb.icb_cmd_wmask;
      @(posedge clk);
      #1;
      if (rsp_fire) begin
        icb.icb_rsp_valid = 1'b0;
        icb.icb_rsp_err   = 1'b0;
      end
      if (cmd_fire) begin
        in_cmd = 1'b0;
        icb.icb_rsp_valid = 1'b1;
        if (c_read) begin
          rd_fire_cnt++;
          if (c_mask != 4'h0) bad_mask++;
          icb.icb_rsp_rdata = read_mem(c_addr);
          icb.icb_rsp_err   = 1'b0;
        end else begin
          wr_fire_cnt++;
          if (c_mask != 4'hF) bad_mask++;
          bad = (wr_fire_cnt == err_wr_at);
          icb.icb_rsp_err   = bad;
          icb.icb_rsp_rdata = '0;
          if (!bad) wr_mem[{c_addr[31:2], 2'b00}] = '{$time, c_wdata};
        end
      end
      if (!icb.icb_cmd_valid) in_cmd = 1'b0;
      else if (!in_cmd) begin
        in_cmd = 1'b1;
        if (icb.icb_cmd_read) begin
          rd_seen++;
          if (rd_seen == stall_rd_at) stall_left = 3;
        end
      end
      if (stall_left > 0) begin
        icb.icb_cmd_ready = 1'b0;
        stall_left--;
      end else begin
        icb.icb_cmd_ready = rand_ready ? ($urandom_range(3) != 0) : 1'b1;
      end
    end
  end

  // Bus monitor: activity counters and stall stability.
  int n_valid_cyc = 0, n_busy_cyc = 0, n_fire = 0, stall_seen = 0, stab_err = 0;
  logic        prev_stall = 1'b0, p_read = 1'b0;
  logic [31:0] p_addr = '0, p_wdata = '0;

  always @(negedge clk) begin
    if (icb.icb_cmd_valid) n_valid_cyc++;
    if (busy) n_busy_cyc++;
    if (icb.icb_cmd_valid && icb.icb_cmd_ready) n_fire++;
    if (prev_stall) begin
      stall_seen++;
      if (!icb.icb_cmd_valid || icb.icb_cmd_addr != p_addr ||
          icb.icb_cmd_read != p_read || icb.icb_cmd_wdata != p_wdata)
        stab_err++;
    end
    prev_stall = icb.icb_cmd_valid && !icb.icb_cmd_ready;
    p_addr     = icb.icb_cmd_addr;
    p_read     = icb.icb_cmd_read;
    p_wdata    = icb.icb_cmd_wdata;
  end

  // Reference: sequential word copy, honouring overlap of earlier writes.
  function automatic void model_copy(input logic [31:0] s, input logic [31:0] d,
                                     input int n, output logic [31:0] exp_q[$]);
    logic [31:0] sa, da, v;
    sa = {s[31:2], 2'b00};
    da = {d[31:2], 2'b00};
    exp_q = {};
    for (int i = 0; i < n; i++) begin
      v = read_mem(sa + 32'(4 * i));
      for (int j = 0; j < i; j++)
        if (da + 32'(4 * j) == sa + 32'(4 * i)) v = exp_q[j];
      exp_q.push_back(v);
    end
  endfunction

  task automatic check_copy(input string tag, input logic [31:0] d, input int n,
                            input logic [31:0] exp_q[$]);
    logic [31:0] da;
    da = {d[31:2], 2'b00};
    for (int i = 0; i < n; i++)
      check($sformatf("%s_w%0d", tag, i), read_mem(da + 32'(4 * i)), exp_q[i]);
  endtask

  task automatic start_xfer(input logic [31:0] s, input logic [31:0] d,
                            input int n, output int t0);
    @(posedge clk);
    #2;
    start = 1'b1;
    src_addr = s;
    dst_addr = d;
    len = LEN_W'(n);
    t0 = cyc;
    @(posedge clk);
    #2;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, output int dcyc);
    bit seen;
    seen = 1'b0;
    dcyc = -1;
    for (int k = 0; k < 400 && !seen; k++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        dcyc = cyc;
      end
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_valid"}, 32'(icb.icb_cmd_valid), 32'd0);
    check({tag, "_rsp_ready"}, 32'(icb.icb_rsp_ready), 32'd0);
    check({tag, "_busy"},      32'(busy), 32'd0);
    check({tag, "_done"},      32'(done), 32'd0);
    check({tag, "_err"},       32'(err), 32'd0);
    check({tag, "_xfer_cnt"},  32'(xfer_cnt), 32'd0);
    check({tag, "_addr"},      icb.icb_cmd_addr, 32'd0);
    check({tag, "_wdata"},     icb.icb_cmd_wdata, 32'd0);
    check({tag, "_wmask"},     32'(icb.icb_cmd_wmask), 32'd0);
    check({tag, "_read"},      32'(icb.icb_cmd_read), 32'd0);
  endtask

  initial begin : main
    logic [31:0] exp_q[$];
    logic [31:0] s, d, keep;
    int t0, dcyc, n, v0, b0, f0;

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    @(negedge clk);
    rst_n = 1'b1;

    // Basic len=4 copy with fixed pattern.
    for (int i = 0; i < 4; i++) poke(32'(4 * i), 32'h1111_1111 * 32'(i + 1));
    model_copy(32'h0, 32'h40, 4, exp_q);
    v0 = n_valid_cyc;
    start_xfer(32'h0, 32'h40, 4, t0);
    check("t1_busy_first", 32'(busy), 32'd1);
    check("t1_valid_first", 32'(icb.icb_cmd_valid), 32'd1);
    check("t1_read_first", 32'(icb.icb_cmd_read), 32'd1);
    check("t1_addr_first", icb.icb_cmd_addr, 32'h0);
    wait_done("t1", dcyc);
    check("t1_latency", 32'(dcyc - t0), 32'd17);
    check("t1_xfer_cnt", 32'(xfer_cnt), 32'd4);
    check("t1_err", 32'(err), 32'd0);
    check("t1_valid_cycles", 32'(n_valid_cyc - v0), 32'd8);
    check_copy("t1_mem", 32'h40, 4, exp_q);

    // len=0: immediate done, no traffic, never busy.
    v0 = n_valid_cyc;
    b0 = n_busy_cyc;
    start_xfer(32'h10, 32'h80, 0, t0);
    wait_done("t2", dcyc);
    check("t2_latency", 32'(dcyc - t0), 32'd1);
    check("t2_valid_cycles", 32'(n_valid_cyc - v0), 32'd0);
    check("t2_busy_cycles", 32'(n_busy_cyc - b0), 32'd0);

    // Second read stalled for three cycles.
    s = 32'h0000_0103;
    d = 32'h0000_0201;
    for (int i = 0; i < 3; i++) poke(32'h100 + 32'(4 * i), $urandom);
    model_copy(s, d, 3, exp_q);
    f0 = rd_fire_cnt;
    b0 = stall_seen;
    v0 = stab_err;
    stall_rd_at = rd_seen + 2;
    start_xfer(s, d, 3, t0);
    wait_done("t3", dcyc);
    stall_rd_at = -1;
    check("t3_latency", 32'(dcyc - t0), 32'd16);
    check("t3_read_handshakes", 32'(rd_fire_cnt - f0), 32'd3);
    check("t3_stall_cycles", 32'(stall_seen - b0), 32'd3);
    check("t3_stable", 32'(stab_err - v0), 32'd0);
    check("t3_xfer_cnt", 32'(xfer_cnt), 32'd3);
    check_copy("t3_mem", d, 3, exp_q);

    // Write error on word 2 of a len=5 copy aborts after one word.
    s = 32'h0000_0300;
    d = 32'h0000_0400;
    for (int i = 0; i < 5; i++) poke(s + 32'(4 * i), $urandom);
    model_copy(s, d, 5, exp_q);
    keep = read_mem(d + 32'h4);
    f0 = n_fire;
    err_wr_at = wr_fire_cnt + 2;
    start_xfer(s, d, 5, t0);
    wait_done("t4", dcyc);
    err_wr_at = -1;
    check("t4_latency", 32'(dcyc - t0), 32'd9);
    check("t4_err", 32'(err), 32'd1);
    check("t4_xfer_cnt", 32'(xfer_cnt), 32'd1);
    repeat (5) @(negedge clk);
    check("t4_cmd_handshakes", 32'(n_fire - f0), 32'd4);
    check("t4_err_sticky", 32'(err), 32'd1);
    check_copy("t4_mem", d, 1, exp_q);
    check("t4_word1_untouched", read_mem(d + 32'h4), keep);

    // len=0 start clears a sticky error.
    start_xfer(32'h10, 32'h80, 0, t0);
    check("t5_err_cleared", 32'(err), 32'd0);
    wait_done("t5", dcyc);

    // Start pulsed mid-transfer is ignored.
    s = 32'h0000_0500;
    d = 32'h0000_0600;
    for (int i = 0; i < 4; i++) poke(s + 32'(4 * i), $urandom);
    model_copy(s, d, 4, exp_q);
    keep = read_mem(32'h700);
    start_xfer(s, d, 4, t0);
    repeat (4) @(posedge clk);
    #2;
    start = 1'b1;
    src_addr = 32'h0000_0700;
    dst_addr = 32'h0000_0700;
    len = 16'd2;
    @(posedge clk);
    #2;
    start = 1'b0;
    wait_done("t6", dcyc);
    check("t6_latency", 32'(dcyc - t0), 32'd17);
    check("t6_xfer_cnt", 32'(xfer_cnt), 32'd4);
    check_copy("t6_mem", d, 4, exp_q);
    check("t6_other_untouched", read_mem(32'h700), keep);

    // Reset during the first write command, then a clean copy.
    s = 32'h0000_0800;
    d = 32'h0000_0900;
    for (int i = 0; i < 3; i++) poke(s + 32'(4 * i), $urandom);
    keep = read_mem(d);
    start_xfer(s, d, 3, t0);
    n = 0;
    while (!(icb.icb_cmd_valid && !icb.icb_cmd_read) && n < 50) begin
      @(posedge clk);
      #2;
      n++;
    end
    check("t7_reached_wr_cmd", 32'(n < 50), 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t7_rst");
    @(negedge clk);
    rst_n = 1'b1;
    check("t7_no_write", read_mem(d), keep);
    s = 32'h0000_0A00;
    d = 32'h0000_0B00;
    for (int i = 0; i < 2; i++) poke(s + 32'(4 * i), $urandom);
    model_copy(s, d, 2, exp_q);
    start_xfer(s, d, 2, t0);
    wait_done("t7b", dcyc);
    check("t7b_latency", 32'(dcyc - t0), 32'd9);
    check("t7b_xfer_cnt", 32'(xfer_cnt), 32'd2);
    check_copy("t7b_mem", d, 2, exp_q);

    // Randomized copies with random ready back-pressure; last one wraps.
    rand_ready = 1'b1;
    for (int it = 0; it < 6; it++) begin
      n = $urandom_range(1, 6);
      s = 32'h0000_2000 + 32'($urandom_range(0, 255) * 4) + 32'($urandom_range(0, 3));
      d = 32'h0000_6000 + 32'($urandom_range(0, 255) * 4) + 32'($urandom_range(0, 3));
      if (it == 5) begin
        s = 32'hFFFF_FFF8 | 32'($urandom_range(0, 3));
        n = 4;
      end
      for (int i = 0; i < n; i++) poke({s[31:2], 2'b00} + 32'(4 * i), $urandom);
      model_copy(s, d, n, exp_q);
      start_xfer(s, d, n, t0);
      wait_done($sformatf("r%0d", it), dcyc);
      check($sformatf("r%0d_xfer_cnt", it), 32'(xfer_cnt), 32'(n));
      check($sformatf("r%0d_err", it), 32'(err), 32'd0);
      check_copy($sformatf("r%0d_mem", it), d, n, exp_q);
    end
    rand_ready = 1'b0;

    check("stall_stability_total", 32'(stab_err), 32'd0);
    check("wmask_protocol", 32'(bad_mask), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
